// File: rtl/fifo_param_pkg.sv
// Shared types and defaults for the parameterised FIFO: control state encoding,
// default sizing constants and an elaboration-time power-of-two check.
package fifo_param_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } fifo_state_t;

    localparam int DEF_WS    = 8;
    localparam int DEF_DEPTH = 8;

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 32'd2) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/fifo_param_regfile.sv
// Storage array for fifo_param: synchronous write port, combinational read by address.
// Contents are deliberately not reset; occupancy tracking makes stale words unreachable.
module regfile_param #(
    parameter int WS    = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WS-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WS-1:0]            rdata
);

    logic [WS-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with registered outputs, threshold flags and sticky error flags.
// Occupancy drives an EMPTY/PARTIAL/FULL control FSM that gates push/pop acceptance.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WS    = DEF_WS,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AF_TH = DEPTH - 1,
    parameter int AE_TH = 1
) (
    input  logic                   clk,
    input  logic                   reset_fifo_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clr_err,
    input  logic [WS-1:0]          DataIn,
    output logic [WS-1:0]          DataOut,
    output logic                   pndng,
    output logic                   full,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_param: DEPTH must be a power of two and at least 2");
    end
    if ((AF_TH < 0) || (AF_TH > DEPTH) || (AE_TH < 0) || (AE_TH > DEPTH)) begin : g_bad_th
        $error("fifo_param: AF_TH and AE_TH must lie within 0..DEPTH");
    end

    fifo_state_t   state_r, state_nx_s;
    logic [AW-1:0] wp_r, rp_r, wp_nx_s, rp_nx_s;
    logic [CW-1:0] count_nx_s;
    logic [WS-1:0] rdata_s, dout_nx_s;
    logic          do_push_s, do_pop_s, ovf_evt_s, udf_evt_s;
    logic          ovf_nx_s, udf_nx_s;

    regfile_param #(
        .WS    (WS),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (do_push_s),
        .waddr (wp_r),
        .wdata (DataIn),
        .raddr (rp_r),
        .rdata (rdata_s)
    );

    // Acceptance, pointer/count update and FSM next state
    always_comb begin
        do_push_s  = 1'b0;
        do_pop_s   = 1'b0;
        ovf_evt_s  = 1'b0;
        udf_evt_s  = 1'b0;
        state_nx_s = state_r;
        wp_nx_s    = wp_r;
        rp_nx_s    = rp_r;
        count_nx_s = count;
        if (flush) begin
            state_nx_s = EMPTY;
            wp_nx_s    = {AW{1'b0}};
            rp_nx_s    = {AW{1'b0}};
            count_nx_s = {CW{1'b0}};
        end else begin
            // A pop frees a slot in the same edge, so a full FIFO still takes push+pop
            do_pop_s  = pop && (state_r != EMPTY);
            do_push_s = push && ((state_r != FULL) || pop);
            ovf_evt_s = push && !do_push_s;
            udf_evt_s = pop && !do_pop_s;
            if (do_push_s) begin
                wp_nx_s = wp_r + AW'(1);
            end else begin
                wp_nx_s = wp_r;
            end
            if (do_pop_s) begin
                rp_nx_s = rp_r + AW'(1);
            end else begin
                rp_nx_s = rp_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_nx_s = count + CW'(1);
                2'b01:   count_nx_s = count - CW'(1);
                default: count_nx_s = count;
            endcase
            case (state_r)
                EMPTY: begin
                    if (do_push_s) begin
                        state_nx_s = PARTIAL;
                    end else begin
                        state_nx_s = EMPTY;
                    end
                end
                PARTIAL: begin
                    if (count_nx_s == CW'(DEPTH)) begin
                        state_nx_s = FULL;
                    end else if (count_nx_s == {CW{1'b0}}) begin
                        state_nx_s = EMPTY;
                    end else begin
                        state_nx_s = PARTIAL;
                    end
                end
                FULL: begin
                    if (do_pop_s && !do_push_s) begin
                        state_nx_s = PARTIAL;
                    end else begin
                        state_nx_s = FULL;
                    end
                end
                default: state_nx_s = EMPTY;
            endcase
        end
        ovf_nx_s  = (overflow && !clr_err) || ovf_evt_s;
        udf_nx_s  = (underflow && !clr_err) || udf_evt_s;
        dout_nx_s = do_pop_s ? rdata_s : DataOut;
    end

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (!reset_fifo_n) begin
            state_r      <= EMPTY;
            wp_r         <= {AW{1'b0}};
            rp_r         <= {AW{1'b0}};
            count        <= {CW{1'b0}};
            DataOut      <= {WS{1'b0}};
            pndng        <= 1'b0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            wp_r         <= wp_nx_s;
            rp_r         <= rp_nx_s;
            count        <= count_nx_s;
            DataOut      <= dout_nx_s;
            pndng        <= (count_nx_s != {CW{1'b0}});
            full         <= (count_nx_s == CW'(DEPTH));
            almost_full  <= (count_nx_s >= CW'(AF_TH));
            almost_empty <= (count_nx_s <= CW'(AE_TH));
            overflow     <= ovf_nx_s;
            underflow    <= udf_nx_s;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed table-driven bench for fifo_param at WS=8, DEPTH=4, AF_TH=3, AE_TH=1.
module tb_fifo_param;

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] din;
        logic [7:0] dout;
        logic [2:0] cnt;
        logic [5:0] flags; // {pndng, full, almost_full, almost_empty, overflow, underflow}
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_fifo_n, flush, push, pop, clr_err;
    logic [7:0] DataIn, DataOut;
    logic       pndng, full, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;
    int vnum  = 0;

    fifo_param #(.WS(8), .DEPTH(4), .AF_TH(3), .AE_TH(1)) dut (
        .clk          (clk),
        .reset_fifo_n (reset_fifo_n),
        .flush        (flush),
        .push         (push),
        .pop          (pop),
        .clr_err      (clr_err),
        .DataIn       (DataIn),
        .DataOut      (DataOut),
        .pndng        (pndng),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic f, input logic pu, input logic po,
                                input logic c, input logic [7:0] di, input logic [7:0] dq,
                                input logic [2:0] n, input logic [5:0] fl);
        vec_t v;
        v.rst_n = r; v.flush = f; v.push = pu; v.pop = po; v.clr = c;
        v.din = di; v.dout = dq; v.cnt = n; v.flags = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, vnum, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset_fifo_n = v.rst_n;
        flush        = v.flush;
        push         = v.push;
        pop          = v.pop;
        clr_err      = v.clr;
        DataIn       = v.din;
        @(posedge clk);
        #1;
        chk("DataOut",      DataOut,               v.dout);
        chk("count",        {5'b00000, count},     {5'b00000, v.cnt});
        chk("pndng",        {7'b0000000, pndng},        {7'b0000000, v.flags[5]});
        chk("full",         {7'b0000000, full},         {7'b0000000, v.flags[4]});
        chk("almost_full",  {7'b0000000, almost_full},  {7'b0000000, v.flags[3]});
        chk("almost_empty", {7'b0000000, almost_empty}, {7'b0000000, v.flags[2]});
        chk("overflow",     {7'b0000000, overflow},     {7'b0000000, v.flags[1]});
        chk("underflow",    {7'b0000000, underflow},    {7'b0000000, v.flags[0]});
        vnum = vnum + 1;
    endtask

    vec_t       tbl_a[$];
    vec_t       tbl_b[$];
    logic [7:0] model_q[$];
    logic [7:0] exp_d;

    initial begin
        reset_fifo_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
        clr_err = 1'b0; DataIn = 8'h00;

        // reset, fill to full, overflow, drain, push+pop on empty, refill
        tbl_a.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,3'd0,6'b000100));
        tbl_a.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b0,8'h99, 8'h00,3'd0,6'b000100));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h11, 8'h00,3'd1,6'b100100));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h22, 8'h00,3'd2,6'b100000));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h33, 8'h00,3'd3,6'b101000));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h44, 8'h00,3'd4,6'b111000));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h55, 8'h00,3'd4,6'b111010));
        tbl_a.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h11,3'd3,6'b101010));
        tbl_a.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h22,3'd2,6'b100010));
        tbl_a.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h33,3'd1,6'b100110));
        tbl_a.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h44,3'd0,6'b000110));
        tbl_a.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h44,3'd0,6'b000100));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b1,1'b0,8'hA5, 8'h44,3'd1,6'b100101));
        tbl_a.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'hA5,3'd0,6'b000101));
        tbl_a.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b1,8'h00, 8'hA5,3'd0,6'b000100));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h01, 8'hA5,3'd1,6'b100100));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h02, 8'hA5,3'd2,6'b100000));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h03, 8'hA5,3'd3,6'b101000));
        tbl_a.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h04, 8'hA5,3'd4,6'b111000));

        // overflow, drain to 2, flush with push, sticky errors, reset at count 3
        tbl_b.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h77, 8'h61,3'd4,6'b111010));
        tbl_b.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h62,3'd3,6'b101010));
        tbl_b.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h63,3'd2,6'b100010));
        tbl_b.push_back(mk(1'b1,1'b1,1'b1,1'b0,1'b0,8'hEE, 8'h63,3'd0,6'b000110));
        tbl_b.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h63,3'd0,6'b000111));
        tbl_b.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b1,8'h00, 8'h63,3'd0,6'b000101));
        tbl_b.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b1,8'h00, 8'h63,3'd0,6'b000100));
        tbl_b.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h01, 8'h63,3'd1,6'b100100));
        tbl_b.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h02, 8'h63,3'd2,6'b100000));
        tbl_b.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h03, 8'h63,3'd3,6'b101000));
        tbl_b.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h04, 8'h63,3'd4,6'b111000));
        tbl_b.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,8'h05, 8'h63,3'd4,6'b111010));
        tbl_b.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h01,3'd3,6'b101010));
        tbl_b.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,8'h06, 8'h00,3'd0,6'b000100));
        tbl_b.push_back(mk(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h00,3'd0,6'b000101));

        foreach (tbl_a[i]) apply(tbl_a[i]);

        // full FIFO streaming push+pop: order preserved across pointer wrap
        model_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 6; i++) begin
            model_q.push_back(8'h60 + 8'(i));
            exp_d = model_q.pop_front();
            apply(mk(1'b1,1'b0,1'b1,1'b1,1'b0,8'h60 + 8'(i), exp_d,3'd4,6'b111000));
        end

        foreach (tbl_b[i]) apply(tbl_b[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
